// File: rtl/sdp_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sdp_scan_driver
// Description : Time-multiplexed scan controller for an 8-digit seven-segment
//               display. Steps the digit index, drives the active-low cathode
//               bus with the hex glyph of the selected digit, snapshots the
//               display data once per frame and blanks each slot's lead-in.
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_scan_driver #(
    parameter int DIV   = 100000,  // clock cycles per digit slot
    parameter int BLANK = 1000     // cathode-off cycles at the start of a slot
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dmask,
    input  logic [7:0]  dpmask,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam logic [19:0] c_cnt_last = 20'(DIV - 1);
    localparam logic [6:0]  c_seg_off  = 7'h7F;

    // Slot phase, derived purely from the slot counter.
    typedef enum logic [0:0] {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    logic [19:0] cnt_q,         cnt_d;
    logic [2:0]  sel_q,         sel_d;
    logic [31:0] data_s_q,      data_s_d;
    logic [7:0]  dmask_s_q,     dmask_s_d;
    logic [7:0]  dpmask_s_q,    dpmask_s_d;
    logic        frame_start_q, frame_start_d;

    logic        w_in_blank;
    phase_e      w_phase;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;

    // Blank-window detect; with no blank window the compare is dropped entirely.
    generate
        if (BLANK > 0) begin : g_blank
            localparam logic [19:0] c_blank = 20'(BLANK);
            assign w_in_blank = (cnt_q < c_blank);
        end else begin : g_no_blank
            assign w_in_blank = 1'b0;
        end
    endgenerate

    assign w_phase = w_in_blank ? PH_BLANK : PH_SHOW;

    // Next-state: slot counter, digit index, end-of-frame snapshot and pulse.
    always_comb begin
        cnt_d         = cnt_q + 20'd1;
        sel_d         = sel_q;
        data_s_d      = data_s_q;
        dmask_s_d     = dmask_s_q;
        dpmask_s_d    = dpmask_s_q;
        frame_start_d = 1'b0;
        if (cnt_q == c_cnt_last) begin
            cnt_d = 20'd0;
            sel_d = sel_q + 3'd1;
            // Last cycle of the last slot: the next cycle begins a new frame,
            // so latch the inputs here to keep the whole frame tear-free.
            if (sel_q == 3'd7) begin
                data_s_d      = data;
                dmask_s_d     = dmask;
                dpmask_s_d    = dpmask;
                frame_start_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= 20'd0;
            sel_q         <= 3'd0;
            data_s_q      <= 32'd0;
            dmask_s_q     <= 8'd0;
            dpmask_s_q    <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            data_s_q      <= data_s_d;
            dmask_s_q     <= dmask_s_d;
            dpmask_s_q    <= dpmask_s_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign w_nibble = data_s_q[{sel_q, 2'b00} +: 4];

    // Hex-to-glyph lookup, cathodes {g,f,e,d,c,b,a} active-low.
    always_comb begin
        case (w_nibble)
            4'h0:    w_glyph = 7'h40;
            4'h1:    w_glyph = 7'h79;
            4'h2:    w_glyph = 7'h24;
            4'h3:    w_glyph = 7'h30;
            4'h4:    w_glyph = 7'h19;
            4'h5:    w_glyph = 7'h12;
            4'h6:    w_glyph = 7'h02;
            4'h7:    w_glyph = 7'h78;
            4'h8:    w_glyph = 7'h00;
            4'h9:    w_glyph = 7'h10;
            4'hA:    w_glyph = 7'h08;
            4'hB:    w_glyph = 7'h03;
            4'hC:    w_glyph = 7'h46;
            4'hD:    w_glyph = 7'h21;
            4'hE:    w_glyph = 7'h06;
            default: w_glyph = 7'h0E;
        endcase
    end

    // Cathode drive from registered state only; dark in blank phase or when masked.
    always_comb begin
        seg = c_seg_off;
        dp  = 1'b1;
        if (w_phase == PH_SHOW && dmask_s_q[sel_q]) begin
            seg = w_glyph;
            dp  = ~dpmask_s_q[sel_q];
        end
    end

    assign sel         = sel_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_sdp_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_scan_driver
// Description : Directed self-checking bench for sdp_scan_driver. One instance
//               with DIV=8/BLANK=2, one with DIV=4/BLANK=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'd0;
    logic [7:0]  dmask = 8'd0;
    logic [7:0]  dpmask = 8'd0;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    logic        rst2 = 1'b1;
    logic [31:0] data2 = 32'd0;
    logic [7:0]  dmask2 = 8'hFF;
    logic [7:0]  dpmask2 = 8'h00;
    logic [2:0]  sel2;
    logic [6:0]  seg2;
    logic        dp2;
    logic        frame_start2;

    int n_vec = 0;
    int n_bad = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sdp_scan_driver #(.DIV(8), .BLANK(2)) u_dut (
        .clk(clk), .rst(rst), .data(data), .dmask(dmask), .dpmask(dpmask),
        .sel(sel), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    sdp_scan_driver #(.DIV(4), .BLANK(0)) u_dut2 (
        .clk(clk), .rst(rst2), .data(data2), .dmask(dmask2), .dpmask(dpmask2),
        .sel(sel2), .seg(seg2), .dp(dp2), .frame_start(frame_start2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk ncyc cycles of one frame of the DIV=8/BLANK=2 instance, checking
    // against the shadow contents the frame should display. Optionally changes
    // the inputs at cycle chg_at.
    task automatic run_frame(input string name, input logic [31:0] ed, input logic [7:0] em,
                             input logic [7:0] ep, input logic fs0, input int ncyc,
                             input int chg_at, input logic [31:0] nd, input logic [7:0] nm,
                             input logic [7:0] np);
        for (int j = 0; j < ncyc; j++) begin
            int s;
            int c;
            logic lit;
            logic [3:0] nib;
            logic [6:0] eseg;
            logic edp;
            s = j / 8;
            c = j % 8;
            if (j == chg_at) begin
                data   = nd;
                dmask  = nm;
                dpmask = np;
            end
            nib  = ed[s*4 +: 4];
            lit  = (c >= 2) && em[s];
            eseg = lit ? glyph_tab[nib] : 7'h7F;
            edp  = lit ? ~ep[s] : 1'b1;
            check($sformatf("%s_j%0d_sel", name, j), 32'(sel), 32'(s));
            check($sformatf("%s_j%0d_seg", name, j), 32'(seg), 32'(eseg));
            check($sformatf("%s_j%0d_dp", name, j), 32'(dp), 32'(edp));
            check($sformatf("%s_j%0d_fs", name, j), 32'(frame_start),
                  32'((j == 0) ? fs0 : 1'b0));
            tick();
        end
    endtask

    initial begin
        // Inputs present from the start but invisible until the first load.
        data   = 32'h76543210;
        dmask  = 8'hFF;
        dpmask = 8'h01;
        rst    = 1'b1;
        tick();
        rst = 1'b0;

        // Frame 1 after reset: dark, no frame_start at cycle 0.
        run_frame("f1", 32'h0, 8'h00, 8'h00, 1'b0, 64, -1, 32'h0, 8'h0, 8'h0);
        // Frame 2: digits 0..7, point on digit 0; data changes mid-frame.
        run_frame("f2", 32'h76543210, 8'hFF, 8'h01, 1'b1, 64, 32, 32'hFFFFFFFF, 8'hFF, 8'h01);
        // Frame 3: all F; new mask pattern applied mid-frame.
        run_frame("f3", 32'hFFFFFFFF, 8'hFF, 8'h01, 1'b1, 64, 10, 32'hFEDCBA98, 8'hA5, 8'h00);
        // Frame 4: masked digits 0,2,5,7 lit.
        run_frame("f4", 32'hFEDCBA98, 8'hA5, 8'h00, 1'b1, 64, -1, 32'h0, 8'h0, 8'h0);
        // Frame 5: stop at slot 5, cnt 4, then reset for one cycle.
        run_frame("f5", 32'hFEDCBA98, 8'hA5, 8'h00, 1'b1, 44, -1, 32'h0, 8'h0, 8'h0);
        check("pre_rst_sel", 32'(sel), 32'd5);
        check("pre_rst_seg", 32'(seg), 32'(glyph_tab[4'hD]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_sel", 32'(sel), 32'd0);
        check("post_rst_seg", 32'(seg), 32'h7F);
        check("post_rst_dp", 32'(dp), 32'd1);
        check("post_rst_fs", 32'(frame_start), 32'd0);
        run_frame("f6", 32'h0, 8'h00, 8'h00, 1'b0, 64, -1, 32'h0, 8'h0, 8'h0);
        run_frame("f7", 32'hFEDCBA98, 8'hA5, 8'h00, 1'b1, 64, -1, 32'h0, 8'h0, 8'h0);

        // DIV=4, BLANK=0 instance: blank first frame, then 0 glyph every cycle.
        tick();
        rst2 = 1'b0;
        for (int j = 0; j < 96; j++) begin
            check($sformatf("d2_j%0d_sel", j), 32'(sel2), 32'((j / 4) % 8));
            check($sformatf("d2_j%0d_seg", j), 32'(seg2), (j < 32) ? 32'h7F : 32'h40);
            check($sformatf("d2_j%0d_dp", j), 32'(dp2), 32'd1);
            check($sformatf("d2_j%0d_fs", j), 32'(frame_start2),
                  ((j > 0) && (j % 32 == 0)) ? 32'd1 : 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdp_scan_driver.md
Name: sdp_scan_driver

Overview:
- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Steps a 3-bit digit index that feeds the existing 3-to-8 active-low anode selector.
- Drives the shared active-low cathode bus with the hex glyph for the digit currently selected.
- Snapshots the display data once per frame so the value never tears mid-scan, and blanks the cathodes at the start of each digit slot to suppress ghosting.

Parameters:
- DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz). Legal range is BLANK+1 to 2^20.
- BLANK, 1000: cycles at the start of each slot with cathodes forced off. Legal range is 0 to DIV-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data  in  32  hex value; digit i uses nibble data[4i+3:4i]
- dmask  in  8  per-digit enable, 1 = digit lit
- dpmask  in  8  per-digit decimal point, 1 = point lit
- sel  out  3  digit index to the anode selector
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal-point cathode, active-low
- frame_start  out  1  one-cycle pulse at the start of each frame (slot 0)

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-high, taking effect on the clk edge where rst=1.
- Registers:
  - cnt: 20 bits, runs 0..DIV-1.
  - sel: 3 bits.
  - shadow: data_s[31:0], dmask_s[7:0], dpmask_s[7:0].
  - frame_start flop.
- Reset values: cnt=0, sel=0, all shadow registers=0, frame_start=0. Hence seg=7'h7F and dp=1.
- The first frame after reset is fully blank, since dmask_s=0.
- Counter:
  - cnt increments every cycle.
  - When cnt==DIV-1, cnt goes to 0 and sel goes to sel+1 mod 8 (7 wraps to 0).
- Shadow load:
  - Happens in the cycle where cnt==DIV-1 and sel==7.
  - data, dmask and dpmask are captured, so they take effect from slot 0 of the next frame.
  - Input changes at any other time are invisible until the next load.
- frame_start is a registered pulse, high exactly during the cycle where cnt==0 and sel==0 following a wrap. It is never high in the cycle immediately after reset.
- Two states, derived from cnt (no separate state register is required):
  - BLANK (cnt < BLANK): seg=7'h7F, dp=1.
  - SHOW (cnt >= BLANK):
    - If dmask_s[sel]=1: seg=glyph(data_s nibble sel), dp=~dpmask_s[sel].
    - If dmask_s[sel]=0: seg=7'h7F, dp=1.
  - With BLANK=0 the BLANK state never occurs.
- Glyph table, 7-bit hex values of seg:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- seg, dp and sel are functions of registered state only. There is no combinational path from any input to any output.
- sel changes on the same edge as the cnt wrap, so each slot begins in BLANK and the anode switch coincides with cathodes off.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and the partially scanned frame is abandoned.
- dmask_s=0 with any data: display stays dark, while sel and frame_start keep cycling.

Test Plan (DIV=8, BLANK=2 unless noted):
- Reset, then hold rst=0 for 64 cycles -> sel=0 throughout slot 0 (cycles 0-7), then 1..7 changing every 8 cycles; seg=7F, dp=1 the whole first frame; frame_start first high on cycle 64, exactly 1 cycle wide.
- data=32'h76543210, dmask=FF, dpmask=01, run 2 frames -> in frame 2, slot i gives seg=7F for cnt 0-1, then the glyph for i for cnt 2-7 (slot 0: 40, slot 3: 30); dp=0 only in slot 0 at cnt>=2.
- Change data to 32'hFFFFFFFF in the middle of frame 2 -> remainder of frame 2 unchanged; frame 3 shows 0E on all digits starting at its slot 0.
- dmask=8'b1010_0101, data=32'hFEDCBA98 -> slots 0, 2, 5, 7 show 00, 08, 21, 0E; slots 1, 3, 4, 6 show 7F; dp stays 1.
- Assert rst for 1 cycle at slot 5, cnt=4 -> next cycle sel=0, cnt=0, seg=7F, frame_start=0; the next full frame is blank.
- DIV=4, BLANK=0, data=0, dmask=FF -> seg=40 on every cycle, sel steps every 4 cycles, frame_start period 32 cycles.
